// File: rtl/half_adder_sub.sv
// Registered lane-parallel half subtractor with valid pipeline and saturating borrow-event counter.
// Define HALF_ADDER_SUB_ADD_MODE_EN to add a 'mode' input selecting half-add (mode=1) per beat.
module half_adder_sub #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
`ifdef HALF_ADDER_SUB_ADD_MODE_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic             borrow_any,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] c_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             cnt_inc;

    // Per-lane arithmetic; lanes never interact.
    always_comb begin
        d_nxt   = a ^ b;
        c_nxt   = ~a & b;
        cnt_inc = in_valid & (|c_nxt);
`ifdef HALF_ADDER_SUB_ADD_MODE_EN
        if (mode) begin
            c_nxt   = a & b;
            cnt_inc = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c          <= '0;
            d          <= '0;
            out_valid  <= 1'b0;
            borrow_any <= 1'b0;
            borrow_cnt <= '0;
        end else begin
            out_valid  <= in_valid;
            borrow_any <= in_valid & (|c_nxt);
            // Result registers hold when idle to avoid needless toggling.
            if (in_valid) begin
                c <= c_nxt;
                d <= d_nxt;
            end
            if (cnt_inc && (borrow_cnt != CNT_MAX)) begin
                borrow_cnt <= borrow_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_half_adder_sub.sv
// Directed self-checking bench for half_adder_sub: WIDTH=1, WIDTH=4 and CNT_W=2 instances.
// Mode tests run when HALF_ADDER_SUB_ADD_MODE_EN is defined.
module tb_half_adder_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       a2 = 1'b0, b2 = 1'b0;

    logic       c1, d1, ov1, any1;
    logic [7:0] cnt1;
    logic [3:0] c4, d4;
    logic       ov4, any4;
    logic [7:0] cnt4;
    logic       c2, d2, ov2, any2;
    logic [1:0] cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    half_adder_sub #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef HALF_ADDER_SUB_ADD_MODE_EN
        .mode(mode),
`endif
        .a(a1), .b(b1), .c(c1), .d(d1), .out_valid(ov1),
        .borrow_any(any1), .borrow_cnt(cnt1)
    );

    half_adder_sub #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef HALF_ADDER_SUB_ADD_MODE_EN
        .mode(mode),
`endif
        .a(a4), .b(b4), .c(c4), .d(d4), .out_valid(ov4),
        .borrow_any(any4), .borrow_cnt(cnt4)
    );

    half_adder_sub #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef HALF_ADDER_SUB_ADD_MODE_EN
        .mode(mode),
`endif
        .a(a2), .b(b2), .c(c2), .d(d2), .out_valid(ov2),
        .borrow_any(any2), .borrow_cnt(cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [1:0] cd, input logic ov,
                        input logic any, input logic [7:0] cnt);
        chk({tag, "_cd"}, 32'({c1, d1}), 32'(cd));
        chk({tag, "_ov"}, 32'(ov1), 32'(ov));
        chk({tag, "_any"}, 32'(any1), 32'(any));
        chk({tag, "_cnt"}, 32'(cnt1), 32'(cnt));
    endtask

    initial begin
        // Reset, with a borrowing beat presented that must be ignored.
        rst = 1'b1; in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        chk1("reset", 2'b00, 1'b0, 1'b0, 8'd0);
        chk("reset_u4_c", 32'(c4), 32'h0);
        chk("reset_u2_cnt", 32'(cnt2), 32'h0);

        // Truth table on WIDTH=1; WIDTH=4 vector alongside.
        rst = 1'b0; in_valid = 1'b1; a1 = 1'b0; b1 = 1'b0;
        a4 = 4'b0101; b4 = 4'b0011;
        tick();
        chk1("tt00", 2'b00, 1'b1, 1'b0, 8'd0);
        chk("w4_d", 32'(d4), 32'h6);
        chk("w4_c", 32'(c4), 32'h2);
        chk("w4_any", 32'(any4), 32'h1);
        chk("w4_cnt", 32'(cnt4), 32'h1);

        a1 = 1'b0; b1 = 1'b1; a4 = 4'b1111; b4 = 4'b0000;
        tick();
        chk1("tt01", 2'b11, 1'b1, 1'b1, 8'd1);
        chk("w4b_d", 32'(d4), 32'hF);
        chk("w4b_c", 32'(c4), 32'h0);
        chk("w4b_any", 32'(any4), 32'h0);
        chk("w4b_cnt", 32'(cnt4), 32'h1);

        a1 = 1'b1; b1 = 1'b0;
        tick();
        chk1("tt10", 2'b01, 1'b1, 1'b0, 8'd1);

        a1 = 1'b1; b1 = 1'b1;
        tick();
        chk1("tt11", 2'b00, 1'b1, 1'b0, 8'd1);

        // Valid beat then idle: outputs hold, out_valid drops.
        a1 = 1'b1; b1 = 1'b0;
        tick();
        chk1("beat10", 2'b01, 1'b1, 1'b0, 8'd1);
        in_valid = 1'b0; a1 = 1'b0; b1 = 1'b1;
        tick();
        chk1("idle_hold", 2'b01, 1'b0, 1'b0, 8'd1);

        // Reset while a borrowing beat is in flight.
        in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        chk1("pre_rst", 2'b11, 1'b1, 1'b1, 8'd2);
        rst = 1'b1;
        tick();
        chk1("mid_rst", 2'b00, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        tick();
        chk1("post_rst", 2'b11, 1'b1, 1'b1, 8'd1);

        // Saturation on CNT_W=2 instance.
        rst = 1'b1; in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        tick();
        rst = 1'b0; in_valid = 1'b1; a2 = 1'b0; b2 = 1'b1;
        tick(); chk("sat1", 32'(cnt2), 32'd1);
        tick(); chk("sat2", 32'(cnt2), 32'd2);
        tick(); chk("sat3", 32'(cnt2), 32'd3);
        tick(); chk("sat4", 32'(cnt2), 32'd3);
        tick(); chk("sat5", 32'(cnt2), 32'd3);
        chk("sat_cd", 32'({c2, d2}), 32'h3);
        chk("sat_u1_cnt", 32'(cnt1), 32'd0);

`ifdef HALF_ADDER_SUB_ADD_MODE_EN
        // Add mode: carry instead of borrow, counter untouched.
        mode = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        chk1("add11", 2'b10, 1'b1, 1'b1, 8'd0);
        a1 = 1'b0; b1 = 1'b1;
        tick();
        chk1("add01", 2'b01, 1'b1, 1'b0, 8'd0);
        mode = 1'b0; a1 = 1'b1; b1 = 1'b1;
        tick();
        chk1("sub11", 2'b00, 1'b1, 1'b0, 8'd0);
`endif

        in_valid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
